// File: rtl/dat_tf_sequencer_if.sv
// Purpose : bundles the control, handshake and status signals between the DAT
//           transfer sequencer and its environment (register file, CMD unit,
//           DAT control/phys pair).
// Latency : none; this is wiring only.
// Backpres: none; the DAT flags are held until dat_phys_busy is seen.
// Ports   : master = environment side (drives requests, card/FIFO status);
//           slave  = sequencer side (drives cmd_issue/cmd_index, DAT flags,
//           blocks_left and the status pulses).
interface dat_tf_sequencer_if #(
    parameter int BLOCK_CNT_WIDTH = 16
);
    // register file requests
    logic                       tf_start;
    logic                       tf_abort;
    logic                       tf_direction_reg;
    logic                       multiple_blk_reg;
    logic                       auto_cmd12_reg;
    logic [BLOCK_CNT_WIDTH-1:0] block_cnt_reg;
    // CMD unit / FIFO / DAT datapath status
    logic                       cmd_done;
    logic                       tx_buf_empty;
    logic                       rx_buf_full;
    logic                       dat_phys_busy;
    logic                       tf_finished;
    // sequencer outputs
    logic                       cmd_issue;
    logic [5:0]                 cmd_index;
    logic                       dat_wr_flag;
    logic                       dat_rd_flag;
    logic [BLOCK_CNT_WIDTH-1:0] blocks_left;
    logic                       tf_active;
    logic                       tf_complete;
    logic                       tf_error;

    modport master (
        output tf_start, tf_abort, tf_direction_reg, multiple_blk_reg,
               auto_cmd12_reg, block_cnt_reg, cmd_done, tx_buf_empty,
               rx_buf_full, dat_phys_busy, tf_finished,
        input  cmd_issue, cmd_index, dat_wr_flag, dat_rd_flag, blocks_left,
               tf_active, tf_complete, tf_error
    );

    modport slave (
        input  tf_start, tf_abort, tf_direction_reg, multiple_blk_reg,
               auto_cmd12_reg, block_cnt_reg, cmd_done, tx_buf_empty,
               rx_buf_full, dat_phys_busy, tf_finished,
        output cmd_issue, cmd_index, dat_wr_flag, dat_rd_flag, blocks_left,
               tf_active, tf_complete, tf_error
    );
endinterface

// File: rtl/dat_tf_sequencer.sv
// Purpose : host-clock sequencer for DAT block transfers: issues CMD17/18/24/25,
//           optional CMD12, gates each block on FIFO readiness, counts blocks.
// Latency : all outputs registered; tf_complete 2 cycles after the last
//           tf_finished (plus STOP/WAIT_STOP and response time with CMD12).
// Backpres: waits in WAIT_BUF on FIFO state; DAT flag held until dat_phys_busy.
// Ports   : host_clk, rst (async active-high); bus = dat_tf_sequencer_if.slave.
// Config  : define DAT_TIMEOUT_EN to bound WAIT_RESP/WAIT_DAT/WAIT_STOP to
//           TIMEOUT_CYCLES cycles each (TO_WIDTH-bit counter).
module dat_tf_sequencer #(
    parameter int BLOCK_CNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int TO_WIDTH        = 13
) (
    input  logic                 host_clk,
    input  logic                 rst,
    dat_tf_sequencer_if.slave    bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_ISSUE, S_WAIT_RESP, S_WAIT_BUF, S_START_DAT,
        S_WAIT_DAT, S_BLK_DONE, S_STOP, S_WAIT_STOP, S_DONE
    } state_t;

    localparam logic [BLOCK_CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [BLOCK_CNT_WIDTH-1:0] CNT_ONE  = BLOCK_CNT_WIDTH'(1);

    state_t                     state;
    state_t                     state_nxt;
    logic                       dir_q;       // 1 = read
    logic                       mult_q;
    logic                       aborted_q;   // current STOP came from an abort
    logic [BLOCK_CNT_WIDTH-1:0] blocks_left_q;

    logic                       err_evt;
    logic                       abort_set;

    logic                       cmd_issue_nxt;
    logic [5:0]                 cmd_index_nxt;
    logic                       dat_wr_nxt;
    logic                       dat_rd_nxt;
    logic                       tf_active_nxt;
    logic                       tf_complete_nxt;
    logic                       dir_eff;
    logic                       mult_eff;

`ifdef DAT_TIMEOUT_EN
    logic [TO_WIDTH-1:0]        to_cnt;

    function automatic logic is_wait(input state_t s);
        return (s == S_WAIT_RESP) || (s == S_WAIT_DAT) || (s == S_WAIT_STOP);
    endfunction
`endif

    // ---------------------------------------------------------------
    // State register (plus transfer context latched alongside it)
    // ---------------------------------------------------------------
    always_ff @(posedge host_clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            dir_q         <= 1'b0;
            mult_q        <= 1'b0;
            aborted_q     <= 1'b0;
            blocks_left_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && state_nxt == S_ISSUE) begin
                dir_q         <= bus.tf_direction_reg;
                mult_q        <= bus.multiple_blk_reg;
                aborted_q     <= 1'b0;
                blocks_left_q <= bus.multiple_blk_reg ? bus.block_cnt_reg : CNT_ONE;
            end else begin
                if (abort_set) begin
                    aborted_q <= 1'b1;
                end
                if (state == S_BLK_DONE && blocks_left_q != CNT_ZERO) begin
                    blocks_left_q <= blocks_left_q - CNT_ONE;
                end
            end
        end
    end

`ifdef DAT_TIMEOUT_EN
    // Restarts on entry to each wait state, counts every cycle spent there.
    always_ff @(posedge host_clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (is_wait(state_nxt) && state_nxt != state) begin
            to_cnt <= '0;
        end else if (is_wait(state)) begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
        end
    end
`endif

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        err_evt   = 1'b0;
        abort_set = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.tf_start) begin
                    if (bus.block_cnt_reg == CNT_ZERO) begin
                        err_evt = 1'b1;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE:     state_nxt = S_WAIT_RESP;
            S_WAIT_RESP: if (bus.cmd_done) state_nxt = S_WAIT_BUF;
            S_WAIT_BUF: begin
                if (dir_q ? !bus.rx_buf_full : !bus.tx_buf_empty) begin
                    state_nxt = S_START_DAT;
                end
            end
            S_START_DAT: begin
                // A finish pulse coinciding with busy rising closes the block.
                if (bus.dat_phys_busy) begin
                    state_nxt = bus.tf_finished ? S_BLK_DONE : S_WAIT_DAT;
                end
            end
            S_WAIT_DAT:  if (bus.tf_finished) state_nxt = S_BLK_DONE;
            S_BLK_DONE: begin
                if (blocks_left_q > CNT_ONE) begin
                    state_nxt = S_WAIT_BUF;
                end else if (mult_q && bus.auto_cmd12_reg) begin
                    state_nxt = S_STOP;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_STOP:      state_nxt = S_WAIT_STOP;
            S_WAIT_STOP: if (bus.cmd_done) state_nxt = aborted_q ? S_IDLE : S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase

`ifdef DAT_TIMEOUT_EN
        if (is_wait(state) && state_nxt == state &&
            to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = S_IDLE;
            err_evt   = 1'b1;
        end
`endif

        // Abort wins over everything. Before the data command is answered
        // the card has nothing to stop; afterwards it needs a CMD12. DONE is
        // left alone because the transfer has already completed.
        if (bus.tf_abort) begin
            case (state)
                S_ISSUE, S_WAIT_RESP: begin
                    state_nxt = S_IDLE;
                    err_evt   = 1'b1;
                end
                S_WAIT_BUF, S_START_DAT, S_WAIT_DAT, S_BLK_DONE: begin
                    state_nxt = S_STOP;
                    err_evt   = 1'b1;
                    abort_set = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Output logic: decoded from the next state so the registered outputs
    // line up with the state they belong to.
    // ---------------------------------------------------------------
    always_comb begin
        // The command index is built in the IDLE->ISSUE cycle, before the
        // transfer context has been latched.
        dir_eff  = (state == S_IDLE) ? bus.tf_direction_reg : dir_q;
        mult_eff = (state == S_IDLE) ? bus.multiple_blk_reg : mult_q;

        cmd_issue_nxt = (state_nxt == S_ISSUE) || (state_nxt == S_STOP);
        cmd_index_nxt = 6'd0;
        if (state_nxt == S_ISSUE) begin
            cmd_index_nxt = dir_eff ? (mult_eff ? 6'd18 : 6'd17)
                                    : (mult_eff ? 6'd25 : 6'd24);
        end else if (state_nxt == S_STOP) begin
            cmd_index_nxt = 6'd12;
        end

        dat_rd_nxt      = (state_nxt == S_START_DAT) && dir_q;
        dat_wr_nxt      = (state_nxt == S_START_DAT) && !dir_q;
        tf_active_nxt   = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        tf_complete_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge host_clk or posedge rst) begin
        if (rst) begin
            bus.cmd_issue   <= 1'b0;
            bus.cmd_index   <= 6'd0;
            bus.dat_wr_flag <= 1'b0;
            bus.dat_rd_flag <= 1'b0;
            bus.tf_active   <= 1'b0;
            bus.tf_complete <= 1'b0;
            bus.tf_error    <= 1'b0;
        end else begin
            bus.cmd_issue   <= cmd_issue_nxt;
            bus.cmd_index   <= cmd_index_nxt;
            bus.dat_wr_flag <= dat_wr_nxt;
            bus.dat_rd_flag <= dat_rd_nxt;
            bus.tf_active   <= tf_active_nxt;
            bus.tf_complete <= tf_complete_nxt;
            bus.tf_error    <= err_evt;
        end
    end

    assign bus.blocks_left = blocks_left_q;

endmodule
